// File: rtl/bt_update_gen_if.sv
// BTUpdate producer bundle: resolved-branch inputs from the branch unit and the
// BTUpdate / status outputs towards the branch target buffer.
interface bt_update_gen_if #(
    parameter int FETCH_OFF_W = 3,
    parameter int DROP_CNT_W  = 16
);
    logic                   IN_res_valid;
    logic [31:0]            IN_res_pc;
    logic [31:0]            IN_res_dst;
    logic [1:0]             IN_res_btype;
    logic                   IN_res_compr;
    logic                   IN_res_taken;
    logic                   IN_res_notBranch;
    logic                   IN_res_btbHit;
    logic [FETCH_OFF_W-1:0] IN_res_fetchOffs;
    logic                   IN_res_prevValid;
    logic [FETCH_OFF_W-1:0] IN_res_prevOffs;

    logic                   OUT_btu_valid;
    logic                   OUT_btu_clean;
    logic                   OUT_btu_multiple;
    logic [FETCH_OFF_W-1:0] OUT_btu_multOffs;
    logic [FETCH_OFF_W-1:0] OUT_btu_fetchOffs;
    logic [31:0]            OUT_btu_src;
    logic [31:0]            OUT_btu_dst;
    logic [1:0]             OUT_btu_btype;
    logic                   OUT_btu_compr;
    logic                   OUT_ready;
    logic [DROP_CNT_W-1:0]  OUT_dropCnt;

    // Update generator side
    modport master (
        input  IN_res_valid, IN_res_pc, IN_res_dst, IN_res_btype, IN_res_compr,
               IN_res_taken, IN_res_notBranch, IN_res_btbHit, IN_res_fetchOffs,
               IN_res_prevValid, IN_res_prevOffs,
        output OUT_btu_valid, OUT_btu_clean, OUT_btu_multiple, OUT_btu_multOffs,
               OUT_btu_fetchOffs, OUT_btu_src, OUT_btu_dst, OUT_btu_btype,
               OUT_btu_compr, OUT_ready, OUT_dropCnt
    );

    // Branch unit / BTB side
    modport slave (
        output IN_res_valid, IN_res_pc, IN_res_dst, IN_res_btype, IN_res_compr,
               IN_res_taken, IN_res_notBranch, IN_res_btbHit, IN_res_fetchOffs,
               IN_res_prevValid, IN_res_prevOffs,
        input  OUT_btu_valid, OUT_btu_clean, OUT_btu_multiple, OUT_btu_multOffs,
               OUT_btu_fetchOffs, OUT_btu_src, OUT_btu_dst, OUT_btu_btype,
               OUT_btu_compr, OUT_ready, OUT_dropCnt
    );
endinterface

// File: rtl/bt_update_gen.sv
// Classifies resolved branches into BTB insert/clean updates, queues them and
// issues at most one per cycle after the BTB's reset sweep.
module bt_update_gen #(
    parameter int BTB_ENTRIES = 1024,
    parameter int FIFO_DEPTH  = 4,
    parameter int FETCH_OFF_W = 3,
    parameter int DROP_CNT_W  = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    bt_update_gen_if.master bus
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int WU_W  = $clog2(BTB_ENTRIES) + 1;

    // Leave WARMUP on the edge where the counter reaches BTB_ENTRIES-1
    localparam logic [WU_W-1:0]  WU_LAST  = (BTB_ENTRIES > 1) ? WU_W'(BTB_ENTRIES - 2) : '0;
    localparam logic [PTR_W-1:0] PTR_MAX  = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_WARMUP,
        ST_RUN,
        ST_BUBBLE
    } state_t;

    typedef struct packed {
        logic                   clean;
        logic                   multiple;
        logic [FETCH_OFF_W-1:0] mult_offs;
        logic [FETCH_OFF_W-1:0] fetch_offs;
        logic [31:0]            src;
        logic [31:0]            dst;
        logic [1:0]             btype;
        logic                   compr;
    } entry_t;

    state_t                state_q;
    logic [WU_W-1:0]       wu_cnt_q;
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic [CNT_W-1:0]      count_q;
    logic [CNT_W-1:0]      count_d;
    logic [DROP_CNT_W-1:0] drop_cnt_q;
    logic                  ready_q;
    logic                  valid_q;
    entry_t                out_q;
    entry_t                mem_q [FIFO_DEPTH];

    entry_t ev_entry;
    entry_t head;
    logic   ev_valid;
    logic   full;
    logic   empty;
    logic   pop;
    logic   push;
    logic   drop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_MAX) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        ev_entry = '0;
        ev_valid = 1'b0;
        if (bus.IN_res_valid) begin
            if (bus.IN_res_notBranch && bus.IN_res_btbHit) begin
                ev_valid            = 1'b1;
                ev_entry.clean      = 1'b1;
                ev_entry.src        = bus.IN_res_pc;
                ev_entry.fetch_offs = bus.IN_res_fetchOffs;
            end else if (bus.IN_res_taken && !bus.IN_res_btbHit) begin
                ev_valid            = 1'b1;
                ev_entry.src        = bus.IN_res_pc;
                ev_entry.dst        = bus.IN_res_dst;
                ev_entry.btype      = bus.IN_res_btype;
                ev_entry.compr      = bus.IN_res_compr;
                ev_entry.fetch_offs = bus.IN_res_fetchOffs;
                // An earlier predicted branch shares the package: it gets the multiple flag
                if (bus.IN_res_prevValid && (bus.IN_res_prevOffs < bus.IN_res_pc[FETCH_OFF_W:1])) begin
                    ev_entry.multiple  = 1'b1;
                    ev_entry.mult_offs = bus.IN_res_prevOffs + FETCH_OFF_W'(1);
                end
            end
        end
    end

    assign full  = (count_q == CNT_FULL);
    assign empty = (count_q == '0);

    // An empty queue forwards the incoming event straight to the output register
    assign head = empty ? ev_entry : mem_q[rd_ptr_q];
    assign pop  = (state_q == ST_RUN) && (!empty || ev_valid);
    assign push = ev_valid && (!full || pop);
    assign drop = ev_valid && !push;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= ev_entry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_WARMUP;
            wu_cnt_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            drop_cnt_q <= '0;
            ready_q    <= 1'b0;
            valid_q    <= 1'b0;
            out_q      <= '0;
        end else begin
            count_q <= count_d;
            if (push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
                out_q    <= head;
            end
            valid_q <= pop;
            if (drop && (drop_cnt_q != '1)) begin
                drop_cnt_q <= drop_cnt_q + DROP_CNT_W'(1);
            end
            ready_q <= (state_q != ST_WARMUP) && !full;

            case (state_q)
                ST_WARMUP: begin
                    wu_cnt_q <= wu_cnt_q + WU_W'(1);
                    if (wu_cnt_q >= WU_LAST) begin
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // Give the BTB one idle slot to commit its cached multiple write
                    if (pop && head.multiple) begin
                        state_q <= ST_BUBBLE;
                    end
                end
                ST_BUBBLE: state_q <= ST_RUN;
                default:   state_q <= ST_WARMUP;
            endcase
        end
    end

    assign bus.OUT_btu_valid     = valid_q;
    assign bus.OUT_btu_clean     = out_q.clean;
    assign bus.OUT_btu_multiple  = out_q.multiple;
    assign bus.OUT_btu_multOffs  = out_q.mult_offs;
    assign bus.OUT_btu_fetchOffs = out_q.fetch_offs;
    assign bus.OUT_btu_src       = out_q.src;
    assign bus.OUT_btu_dst       = out_q.dst;
    assign bus.OUT_btu_btype     = out_q.btype;
    assign bus.OUT_btu_compr     = out_q.compr;
    assign bus.OUT_ready         = ready_q;
    assign bus.OUT_dropCnt       = drop_cnt_q;

endmodule
